cpu7_trap_ctrl: RTL and testbench

Parametrised trap and interrupt sequencer for the next-generation core.
- Replaces the single-timer exception path with NIRQ maskable interrupt channels, plus the illegal-instruction exception and mret.
- Serialises every pipeline redirect through an explicit drain handshake (empty_pipeline_req / empty_pipeline_ackW).
- Generates the CSR write strobes for mepc, mcause and mstatus.
- Sits between the controller/CSR file and the fetch-stage pcnext mux.

---
 rtl/cpu7_trap_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cpu7_trap_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu7_trap_ctrl.sv
// Trap/interrupt sequencer: picks one event in IDLE, drains the pipeline,
// then issues a single-cycle redirect with the matching CSR write strobes.

module cpu7_trap_pend_ch (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic clr,
    output logic pend
);
    // The clear from servicing this channel beats a same-cycle request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   pend <= 1'b0;
        else if (clr) pend <= 1'b0;
        else if (irq) pend <= 1'b1;
    end
endmodule

module cpu7_trap_ctrl #(
    parameter int XLEN           = 32,
    parameter int NIRQ           = 4,
    parameter int IRQ_CAUSE_BASE = 16,
    parameter int DRAIN_MAX      = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] excp_pc,
    input  logic            excp_illinstr,
    input  logic            mret,
    input  logic [NIRQ-1:0] irq,
    input  logic [NIRQ-1:0] irq_en,
    input  logic            mie_global,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    input  logic            empty_pipeline_ackW,
    output logic            empty_pipeline_req,
    output logic            flush_pc_ena,
    output logic [XLEN-1:0] flush_pc,
    output logic            mepc_wr,
    output logic [XLEN-1:0] mepc,
    output logic            mcause_wr,
    output logic [XLEN-1:0] mcause,
    output logic            mstatus_trap,
    output logic            mstatus_mret,
    output logic [NIRQ-1:0] irq_pending,
    output logic            drain_timeout,
    output logic            busy
);
    localparam int CH_W  = (NIRQ > 1) ? $clog2(NIRQ) : 1;
    localparam int CNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);
    localparam logic [XLEN-1:0]  CAUSE_ILL = XLEN'(2);

    typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;
    typedef enum logic [1:0] {K_TRAP, K_RET, K_IRQ} kind_t;
    typedef struct packed {
        kind_t           kind;
        logic [CH_W-1:0] ch;
    } evt_t;

    state_t           state;
    evt_t             evt;
    logic [CNT_W-1:0] cnt;
    logic [NIRQ-1:0]  irq_hit;
    logic [NIRQ-1:0]  svc_clr;
    logic             sel_vld;
    logic [CH_W-1:0]  sel_ch;
    logic [XLEN-1:0]  sel_code;
    logic [XLEN-1:0]  svc_code;
    logic [XLEN-1:0]  trap_tgt;

    function automatic logic [XLEN-1:0] irq_code(input logic [CH_W-1:0] ch);
        return XLEN'(IRQ_CAUSE_BASE) + XLEN'(ch);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NIRQ; gi++) begin : g_ch
            assign svc_clr[gi] = (state == REDIRECT) && (evt.kind == K_IRQ) &&
                                 (evt.ch == CH_W'(gi));
            cpu7_trap_pend_ch u_pend (
                .clk   (clk),
                .reset (reset),
                .irq   (irq[gi]),
                .clr   (svc_clr[gi]),
                .pend  (irq_pending[gi])
            );
        end
    endgenerate

    assign irq_hit = irq_pending & irq_en & {NIRQ{mie_global}};

    // Lowest enabled pending channel wins
    always_comb begin
        sel_vld = 1'b0;
        sel_ch  = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq_hit[i]) begin
                sel_vld = 1'b1;
                sel_ch  = CH_W'(i);
            end
        end
    end

    assign sel_code = irq_code(sel_ch);
    assign svc_code = irq_code(evt.ch);
    assign trap_tgt = {csr_mtvec[XLEN-1:2], 2'b00} +
                      (((evt.kind == K_IRQ) && (csr_mtvec[1:0] == 2'b01)) ?
                       (svc_code << 2) : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            evt                <= '{kind: K_TRAP, ch: '0};
            cnt                <= '0;
            empty_pipeline_req <= 1'b0;
            busy               <= 1'b0;
            flush_pc_ena       <= 1'b0;
            flush_pc           <= '0;
            mepc_wr            <= 1'b0;
            mepc               <= '0;
            mcause_wr          <= 1'b0;
            mcause             <= '0;
            mstatus_trap       <= 1'b0;
            mstatus_mret       <= 1'b0;
            drain_timeout      <= 1'b0;
        end else begin
            flush_pc_ena  <= 1'b0;
            flush_pc      <= '0;
            mepc_wr       <= 1'b0;
            mcause_wr     <= 1'b0;
            mstatus_trap  <= 1'b0;
            mstatus_mret  <= 1'b0;
            drain_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (excp_illinstr || mret || sel_vld) begin
                        state              <= DRAIN;
                        empty_pipeline_req <= 1'b1;
                        busy               <= 1'b1;
                    end
                    if (excp_illinstr) begin
                        evt    <= '{kind: K_TRAP, ch: '0};
                        mepc   <= excp_pc;
                        mcause <= CAUSE_ILL;
                    end else if (mret) begin
                        evt <= '{kind: K_RET, ch: '0};
                    end else if (sel_vld) begin
                        evt    <= '{kind: K_IRQ, ch: sel_ch};
                        mepc   <= excp_pc;
                        mcause <= {1'b1, sel_code[XLEN-2:0]};
                    end
                end
                DRAIN: begin
                    if (empty_pipeline_ackW || cnt == CNT_LAST) begin
                        state         <= REDIRECT;
                        flush_pc_ena  <= 1'b1;
                        drain_timeout <= !empty_pipeline_ackW;
                        if (evt.kind == K_RET) begin
                            mstatus_mret <= 1'b1;
                            flush_pc     <= csr_mepc;
                        end else begin
                            mepc_wr      <= 1'b1;
                            mcause_wr    <= 1'b1;
                            mstatus_trap <= 1'b1;
                            flush_pc     <= trap_tgt;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REDIRECT: begin
                    state              <= IDLE;
                    cnt                <= '0;
                    empty_pipeline_req <= 1'b0;
                    busy               <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu7_trap_ctrl.sv
// Directed-vector bench for cpu7_trap_ctrl with hand-computed expectations.

module tb_cpu7_trap_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] excp_pc;
    logic        excp_illinstr;
    logic        mret;
    logic [3:0]  irq;
    logic [3:0]  irq_en;
    logic        mie_global;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        empty_pipeline_ackW;
    logic        empty_pipeline_req;
    logic        flush_pc_ena;
    logic [31:0] flush_pc;
    logic        mepc_wr;
    logic [31:0] mepc;
    logic        mcause_wr;
    logic [31:0] mcause;
    logic        mstatus_trap;
    logic        mstatus_mret;
    logic [3:0]  irq_pending;
    logic        drain_timeout;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu7_trap_ctrl #(.XLEN(32), .NIRQ(4), .IRQ_CAUSE_BASE(16), .DRAIN_MAX(64)) dut (
        .clk                 (clk),
        .reset               (reset),
        .excp_pc             (excp_pc),
        .excp_illinstr       (excp_illinstr),
        .mret                (mret),
        .irq                 (irq),
        .irq_en              (irq_en),
        .mie_global          (mie_global),
        .csr_mtvec           (csr_mtvec),
        .csr_mepc            (csr_mepc),
        .empty_pipeline_ackW (empty_pipeline_ackW),
        .empty_pipeline_req  (empty_pipeline_req),
        .flush_pc_ena        (flush_pc_ena),
        .flush_pc            (flush_pc),
        .mepc_wr             (mepc_wr),
        .mepc                (mepc),
        .mcause_wr           (mcause_wr),
        .mcause              (mcause),
        .mstatus_trap        (mstatus_trap),
        .mstatus_mret        (mstatus_mret),
        .irq_pending         (irq_pending),
        .drain_timeout       (drain_timeout),
        .busy                (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_strobes(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, flush_pc_ena, mepc_wr, mcause_wr, mstatus_trap,
                  mstatus_mret, drain_timeout, empty_pipeline_req}, {25'd0, exp});
    endtask

    int cyc;

    initial begin
        reset = 1'b0; excp_pc = '0; excp_illinstr = 0; mret = 0; irq = '0;
        irq_en = '0; mie_global = 0; csr_mtvec = '0; csr_mepc = '0;
        empty_pipeline_ackW = 0;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pend", {28'd0, irq_pending}, 32'd0);
        chk_strobes("rst_strobes", 7'b0);
        chk("rst_mcause", mcause, 32'd0);
        reset = 1'b1;

        // illegal instruction, ack at the third drain edge
        excp_pc = 32'h100; csr_mtvec = 32'h200; excp_illinstr = 1;
        tick(); excp_illinstr = 0;
        chk("ill_busy", {31'd0, busy}, 32'd1);
        chk("ill_cap_cause", mcause, 32'd2);
        chk("ill_cap_pc", mepc, 32'h100);
        chk_strobes("ill_drain1", 7'b0000001);
        tick(); chk_strobes("ill_drain2", 7'b0000001);
        tick(); chk_strobes("ill_drain3", 7'b0000001);
        empty_pipeline_ackW = 1;
        tick(); empty_pipeline_ackW = 0;
        chk_strobes("ill_redir", 7'b1111001);
        chk("ill_flush_pc", flush_pc, 32'h200);
        chk("ill_mepc", mepc, 32'h100);
        chk("ill_mcause", mcause, 32'd2);
        tick();
        chk_strobes("ill_idle", 7'b0);
        chk("ill_idle_busy", {31'd0, busy}, 32'd0);
        chk("ill_mepc_hold", mepc, 32'h100);

        // two interrupts, vectored mtvec, lowest channel first
        csr_mtvec = 32'h1001; irq_en = 4'hF; mie_global = 1; excp_pc = 32'h300;
        irq = 4'b0110;
        tick(); irq = '0;
        chk("irq_latch", {28'd0, irq_pending}, 32'h6);
        chk("irq_latch_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("irq1_busy", {31'd0, busy}, 32'd1);
        chk("irq1_mcause", mcause, 32'h8000_0011);
        chk("irq1_mepc", mepc, 32'h300);
        empty_pipeline_ackW = 1;
        tick(); empty_pipeline_ackW = 0;
        chk_strobes("irq1_redir", 7'b1111001);
        chk("irq1_flush_pc", flush_pc, 32'h1044);
        tick();
        chk("irq1_pend_after", {28'd0, irq_pending}, 32'h4);
        chk("irq1_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("irq2_mcause", mcause, 32'h8000_0012);
        empty_pipeline_ackW = 1;
        tick(); empty_pipeline_ackW = 0;
        chk_strobes("irq2_redir", 7'b1111001);
        chk("irq2_flush_pc", flush_pc, 32'h1048);
        tick();
        chk("irq2_pend_after", {28'd0, irq_pending}, 32'h0);

        // illegal + mret + irq0 together: illegal trap wins
        irq_en = 4'h0; csr_mtvec = 32'h200; excp_pc = 32'h400;
        excp_illinstr = 1; mret = 1; irq = 4'b0001;
        tick(); excp_illinstr = 0; mret = 0; irq = '0;
        chk("pri_mcause", mcause, 32'd2);
        chk("pri_pend", {28'd0, irq_pending}, 32'h1);
        empty_pipeline_ackW = 1;
        tick(); empty_pipeline_ackW = 0;
        chk_strobes("pri_redir", 7'b1111001);
        chk("pri_flush_pc", flush_pc, 32'h200);
        tick();
        chk("pri_pend_after", {28'd0, irq_pending}, 32'h1);

        // mret, ack after one drain cycle
        csr_mepc = 32'hABC; mret = 1;
        tick(); mret = 0;
        chk("ret_busy", {31'd0, busy}, 32'd1);
        tick();
        empty_pipeline_ackW = 1;
        tick(); empty_pipeline_ackW = 0;
        chk_strobes("ret_redir", 7'b1000101);
        chk("ret_flush_pc", flush_pc, 32'hABC);
        chk("ret_mepc_hold", mepc, 32'h400);
        chk("ret_mcause_hold", mcause, 32'd2);
        tick();

        // drain timeout; squashed illegal/mret and a late irq during drain
        irq_en = 4'hF; mie_global = 0; excp_pc = 32'h500; excp_illinstr = 1;
        tick(); excp_illinstr = 0;
        cyc = 0;
        while (cyc < 200) begin
            if (cyc == 5) begin
                excp_illinstr = 1; mret = 1; excp_pc = 32'h600; irq = 4'b1000;
            end else begin
                excp_illinstr = 0; mret = 0; irq = '0;
            end
            tick();
            cyc++;
            if (flush_pc_ena) break;
        end
        excp_illinstr = 0; mret = 0; irq = '0;
        chk("to_cycles", cyc, 32'd64);
        chk_strobes("to_redir", 7'b1111011);
        chk("to_mepc", mepc, 32'h500);
        chk("to_mcause", mcause, 32'd2);
        tick();
        chk_strobes("to_idle", 7'b0);
        tick(); tick();
        chk("nomie_busy", {31'd0, busy}, 32'd0);
        chk("nomie_pend", {28'd0, irq_pending}, 32'h9);

        // asynchronous reset in the middle of a drain
        excp_illinstr = 1;
        tick(); excp_illinstr = 0;
        tick();
        chk("ar_pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_pend", {28'd0, irq_pending}, 32'h0);
        chk_strobes("ar_strobes", 7'b0);
        chk("ar_mepc", mepc, 32'h0);
        chk("ar_mcause", mcause, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
